boot_sequencer: RTL

- Parametrised successor to the ad-hoc reset/ready gating in the toplevel: the SD "wait up to 2 s" logic, the coldboot RAM-scramble counter and the resb AND-term.
- Combines NUM_SRC ready sources (RAM, flash, SD image, ...). Each source can wait indefinitely or be released by a per-source timeout.
- Sequences the core reset through explicit states with a guaranteed reset hold time.
- Generates the RAM address scramble value on each coldboot request. Sits between sysctrl/memory controllers and the atarist core.

---
 rtl/boot_sequencer_if.sv | 27 ++
 rtl/boot_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer_if.sv
// Boot sequencer bundle: sysctrl/memory-controller requests in, core reset controls out.
// master = the request/ready side, slave = the sequencer itself.
interface boot_sequencer_if #(
    parameter int NUM_SRC    = 4,
    parameter int SCRAMBLE_W = 2
);
    logic [NUM_SRC-1:0]    src_ready;
    logic                  sys_reset;
    logic                  coldboot;
    logic                  btn_reset;
    logic                  porb;
    logic                  resb;
    logic [SCRAMBLE_W-1:0] scramble;
    logic [1:0]            state;
    logic [NUM_SRC-1:0]    src_ok;
    logic [NUM_SRC-1:0]    src_timed_out;

    modport master (
        output src_ready, sys_reset, coldboot, btn_reset,
        input  porb, resb, scramble, state, src_ok, src_timed_out
    );

    modport slave (
        input  src_ready, sys_reset, coldboot, btn_reset,
        output porb, resb, scramble, state, src_ok, src_timed_out
    );
endinterface

// File: rtl/boot_sequencer.sv
// Core reset sequencer: gathers ready sources (with optional timeout), holds resb, scrambles RAM on coldboot.
// Latency: 2-cycle input sync; resb rises HOLD_CYC cycles after HOLD entry. No backpressure: levels only.
// Optional RSTSEQ_DEBOUNCE_EN adds a DEBOUNCE_CYC stability filter on the synchronised button.
module boot_sequencer #(
    parameter int                 NUM_SRC      = 4,
    parameter int                 CLK_HZ       = 32000000,
    parameter int                 TIMEOUT_MS   = 2000,
    parameter logic [NUM_SRC-1:0] TIMEOUT_MASK = 4'b1000,
    parameter int                 HOLD_CYC     = 16,
    parameter int                 SCRAMBLE_W   = 2,
    parameter int                 DEBOUNCE_CYC = 65536
) (
    input  logic             clk,
    input  logic             reset_n,
    boot_sequencer_if.slave  bus
);

    localparam logic [31:0] TIMEOUT_CYC = 32'(CLK_HZ / 1000 * TIMEOUT_MS);
    localparam int          HW          = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_SRC-1:0]    src_meta_q, src_sync_q;
    logic                  btn_meta_q, btn_sync_q;
    logic                  btn_lvl;
    logic                  coldboot_q;
    logic                  porb_q, porb_d;
    logic                  resb_q, resb_d;
    logic                  por_cnt_q, por_cnt_d;
    logic [31:0]           to_cnt_q, to_cnt_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [SCRAMBLE_W-1:0] scramble_q, scramble_d;
    logic [NUM_SRC-1:0]    src_ok_q, src_ok_d;
    logic [NUM_SRC-1:0]    src_to_q, src_to_d;
    logic                  cb_rise;
    logic                  reset_req;
    logic                  to_reach;
    logic                  all_ok;

`ifdef RSTSEQ_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);

    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           btn_lvl_q, btn_lvl_d;

    // Level only flips after DEBOUNCE_CYC consecutive cycles of disagreement.
    always_comb begin
        db_cnt_d  = '0;
        btn_lvl_d = btn_lvl_q;
        if (btn_sync_q != btn_lvl_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYC - 1)) begin
                btn_lvl_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_q  <= '0;
            btn_lvl_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            btn_lvl_q <= btn_lvl_d;
        end
    end

    assign btn_lvl = btn_lvl_q;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYC != 0);
    assign btn_lvl         = btn_sync_q;
`endif

    always_comb begin
        cb_rise    = bus.coldboot & ~coldboot_q;
        reset_req  = bus.sys_reset | btn_lvl | cb_rise;
        state_d    = state_q;
        porb_d     = porb_q;
        por_cnt_d  = por_cnt_q;
        to_cnt_d   = '0;
        hold_cnt_d = hold_cnt_q;
        scramble_d = scramble_q;
        src_ok_d   = src_ok_q;
        src_to_d   = src_to_q;

        if (state_q != ST_POR && cb_rise) begin
            scramble_d = scramble_q + 1'b1;
        end

        if (state_q == ST_WAIT) begin
            to_cnt_d = (to_cnt_q == TIMEOUT_CYC) ? to_cnt_q : to_cnt_q + 32'd1;
        end
        to_reach = (state_q == ST_WAIT) && (to_cnt_d == TIMEOUT_CYC);

        // Masked sources latch once satisfied; unmasked ones track the live level.
        if (state_q != ST_POR) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (TIMEOUT_MASK[i]) begin
                    if (src_sync_q[i]) begin
                        src_ok_d[i] = 1'b1;
                    end else if (to_reach && !src_ok_q[i]) begin
                        src_ok_d[i] = 1'b1;
                        src_to_d[i] = 1'b1;
                    end
                end else begin
                    src_ok_d[i] = src_sync_q[i];
                end
            end
        end
        all_ok = &src_ok_d;

        case (state_q)
            ST_POR: begin
                if (por_cnt_q) begin
                    state_d = ST_WAIT;
                    porb_d  = 1'b1;
                end else begin
                    por_cnt_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (all_ok) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!all_ok) begin
                    state_d = ST_WAIT;
                end else if (reset_req) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                // A lost live source outranks any simultaneous reset request.
                if (!all_ok) begin
                    state_d = ST_WAIT;
                end else if (reset_req) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            default: state_d = ST_POR;
        endcase

        resb_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_POR;
            src_meta_q <= '0;
            src_sync_q <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            coldboot_q <= 1'b0;
            porb_q     <= 1'b0;
            resb_q     <= 1'b0;
            por_cnt_q  <= 1'b0;
            to_cnt_q   <= '0;
            hold_cnt_q <= '0;
            scramble_q <= '0;
            src_ok_q   <= '0;
            src_to_q   <= '0;
        end else begin
            state_q    <= state_d;
            src_meta_q <= bus.src_ready;
            src_sync_q <= src_meta_q;
            btn_meta_q <= bus.btn_reset;
            btn_sync_q <= btn_meta_q;
            coldboot_q <= bus.coldboot;
            porb_q     <= porb_d;
            resb_q     <= resb_d;
            por_cnt_q  <= por_cnt_d;
            to_cnt_q   <= to_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            scramble_q <= scramble_d;
            src_ok_q   <= src_ok_d;
            src_to_q   <= src_to_d;
        end
    end

    assign bus.porb          = porb_q;
    assign bus.resb          = resb_q;
    assign bus.scramble      = scramble_q;
    assign bus.state         = state_q;
    assign bus.src_ok        = src_ok_q;
    assign bus.src_timed_out = src_to_q;

endmodule
